// File: rtl/read_sram.sv
// Read-side SRAM port for one output channel of the multiport cache.
// Accepts block addresses, issues SRAM reads, captures the returned words into a
// first-word-fall-through output buffer, and releases each block address to the
// free list once its word has been captured.
module read_sram #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned OBUF_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // Block address request stream
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_rd_addr_vld,
  input  logic              i_rd_last,
  output logic              o_rd_addr_rdy,
  // SRAM read port
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_r_en,
  input  logic [DATA_W-1:0] i_sram_data,
  // Output word stream
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_vld,
  output logic              o_data_last,
  input  logic              i_data_rdy,
  // Free list return
  output logic [ADDR_W-1:0] o_free_addr,
  output logic              o_free_vld
);

  localparam int unsigned PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OBUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OBUF_DEPTH);

  // Credit counter: words issued to the SRAM but not yet handed to the output port.
  logic [CNT_W-1:0]  r_cnt;

  // Issue stage registers (drive the SRAM directly)
  logic [ADDR_W-1:0] r_sram_addr;
  logic              r_sram_r_en;
  logic              r_iss_last;

  // Read pipeline tracking each outstanding SRAM read
  logic              r_pipe_vld  [RD_LAT];
  logic              r_pipe_last [RD_LAT];
  logic [ADDR_W-1:0] r_pipe_addr [RD_LAT];

  // Free list return registers
  logic [ADDR_W-1:0] r_free_addr;
  logic              r_free_vld;

  // Output buffer storage and bookkeeping
  logic [DATA_W-1:0] r_buf_data [OBUF_DEPTH];
  logic [OBUF_DEPTH-1:0] r_buf_last;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_ent;

  logic              w_accept;
  logic              w_pop;
  logic              w_empty;
  logic              w_ret_vld;
  logic              w_ret_last;
  logic [ADDR_W-1:0] w_ret_addr;

  // Handshake decode; rdy depends only on registered credit so it never loops back.
  always_comb begin
    o_rd_addr_rdy = !i_rst && (r_cnt < CNT_MAX);
    w_accept      = i_rd_addr_vld && o_rd_addr_rdy;
    w_empty       = (r_ent == '0);
    o_data_vld    = !w_empty;
    w_pop         = o_data_vld && i_data_rdy;
    o_data        = r_buf_data[r_rd_ptr];
    o_data_last   = r_buf_last[r_rd_ptr];
    w_ret_vld     = r_pipe_vld[RD_LAT-1];
    w_ret_last    = r_pipe_last[RD_LAT-1];
    w_ret_addr    = r_pipe_addr[RD_LAT-1];
  end

  assign o_sram_addr = r_sram_addr;
  assign o_sram_r_en = r_sram_r_en;
  assign o_free_addr = r_free_addr;
  assign o_free_vld  = r_free_vld;

  // Credit counter: accept and pop in the same cycle cancel out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      unique case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Issue stage: launch one SRAM read per accepted request, idle address is zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sram_addr <= '0;
      r_sram_r_en <= 1'b0;
      r_iss_last  <= 1'b0;
    end else if (w_accept) begin
      r_sram_addr <= i_rd_addr;
      r_sram_r_en <= 1'b1;
      r_iss_last  <= i_rd_last;
    end else begin
      r_sram_addr <= '0;
      r_sram_r_en <= 1'b0;
      r_iss_last  <= 1'b0;
    end
  end

  // First pipeline stage captures the read as it is presented to the SRAM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pipe_vld[0]  <= 1'b0;
      r_pipe_last[0] <= 1'b0;
      r_pipe_addr[0] <= '0;
    end else begin
      r_pipe_vld[0]  <= r_sram_r_en;
      r_pipe_last[0] <= r_iss_last;
      r_pipe_addr[0] <= r_sram_addr;
    end
  end

  // Remaining pipeline stages match the SRAM read latency.
  for (genvar g = 1; g < RD_LAT; g++) begin : g_pipe
    // Shift one stage; reset flushes reads so late SRAM data is ignored.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_pipe_vld[g]  <= 1'b0;
        r_pipe_last[g] <= 1'b0;
        r_pipe_addr[g] <= '0;
      end else begin
        r_pipe_vld[g]  <= r_pipe_vld[g-1];
        r_pipe_last[g] <= r_pipe_last[g-1];
        r_pipe_addr[g] <= r_pipe_addr[g-1];
      end
    end
  end

  // Release the block address once its word lands in the buffer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_free_addr <= '0;
      r_free_vld  <= 1'b0;
    end else if (w_ret_vld) begin
      r_free_addr <= w_ret_addr;
      r_free_vld  <= 1'b1;
    end else begin
      r_free_addr <= '0;
      r_free_vld  <= 1'b0;
    end
  end

  // Buffer storage write; contents need no reset since r_ent gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_ret_vld) begin
      r_buf_data[r_wr_ptr] <= i_sram_data;
      r_buf_last[r_wr_ptr] <= w_ret_last;
    end
  end

  // Buffer pointers and entry count; credit guarantees no overflow on write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ent    <= '0;
    end else begin
      if (w_ret_vld) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_ret_vld, w_pop})
        2'b10:   r_ent <= r_ent + CNT_W'(1);
        2'b01:   r_ent <= r_ent - CNT_W'(1);
        default: r_ent <= r_ent;
      endcase
    end
  end

endmodule

// File: tb/tb_read_sram.sv
// Scoreboard bench for read_sram: the driver pushes expected words and free
// addresses on every accepted request; independent monitors pop and compare.
module tb_read_sram;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned RD_LAT     = 1;
  localparam int unsigned OBUF_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_vld;
  logic              rd_last;
  logic              rd_rdy;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_r_en;
  logic [DATA_W-1:0] sram_data;
  logic [DATA_W-1:0] data;
  logic              data_vld;
  logic              data_last;
  logic              data_rdy;
  logic [ADDR_W-1:0] free_addr;
  logic              free_vld;

  read_sram #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RD_LAT    (RD_LAT),
    .OBUF_DEPTH(OBUF_DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rd_addr    (rd_addr),
    .i_rd_addr_vld(rd_vld),
    .i_rd_last    (rd_last),
    .o_rd_addr_rdy(rd_rdy),
    .o_sram_addr  (sram_addr),
    .o_sram_r_en  (sram_r_en),
    .i_sram_data  (sram_data),
    .o_data       (data),
    .o_data_vld   (data_vld),
    .o_data_last  (data_last),
    .i_data_rdy   (data_rdy),
    .o_free_addr  (free_addr),
    .o_free_vld   (free_vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model, one cycle read latency
  logic [DATA_W-1:0] sram_mem [256];
  always @(posedge clk) sram_data <= sram_r_en ? sram_mem[sram_addr] : 32'hDEAD_BEEF;

  logic [DATA_W:0]   exp_q[$];
  logic [ADDR_W-1:0] exp_free_q[$];
  int                pop_cycles[$];
  int                free_cnt = 0;
  int                n_checks = 0;
  int                n_errors = 0;
  int                acc_cyc  = 0;
  int                n_wait   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word monitor
  always @(negedge clk) begin
    logic [DATA_W:0] e;
    if (!rst && data_vld && data_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_word: got 0x%0h expected none (cycle %0d)", data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", 64'(data), 64'(e[DATA_W-1:0]));
        chk("word_last", 64'(data_last), 64'(e[DATA_W]));
        pop_cycles.push_back(cyc);
      end
    end
  end

  // Free-list monitor
  always @(negedge clk) begin
    if (!rst && free_vld) begin
      if (exp_free_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_free: got 0x%0h expected none (cycle %0d)", free_addr, cyc);
      end else begin
        chk("free_addr", 64'(free_addr), 64'(exp_free_q.pop_front()));
        free_cnt++;
      end
    end
  end

  // Offer one request, starting and ending just after a rising edge.
  task automatic send(input logic [7:0] a, input logic l, input int budget, output bit ok);
    int w = 0;
    ok = 1'b0;
    rd_vld  = 1'b1;
    rd_addr = a;
    rd_last = l;
    while (!ok && w <= budget) begin
      @(negedge clk);
      if (rd_rdy) begin
        ok = 1'b1;
        acc_cyc = cyc;
        exp_q.push_back({l, sram_mem[a]});
        exp_free_q.push_back(a);
      end else begin
        w++;
      end
      @(posedge clk); #1;
    end
    if (!ok) w--;
    n_wait += w;
    rd_vld = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int w = 0;
    while ((exp_q.size() != 0 || exp_free_q.size() != 0) && w < 60) begin
      step(1);
      w++;
    end
    chk(name, 64'(exp_q.size() + exp_free_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks + 1, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c0;
    int acc;
    int bad;
    int fbase;
    for (int a = 0; a < 256; a++) begin
      sram_mem[a] = {8'hC0, 8'(a), 8'h5A, 8'(a) ^ 8'hFF};
    end
    sram_mem[5] = 32'hA5A5_0001;

    // 1: reset held with a pending request
    rst = 1'b1; rd_vld = 1'b1; rd_addr = 8'h77; rd_last = 1'b1; data_rdy = 1'b0;
    step(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rdy", 64'(rd_rdy), 64'd0);
      if (i > 0) begin
        chk("rst_r_en", 64'(sram_r_en), 64'd0);
        chk("rst_sram_addr", 64'(sram_addr), 64'd0);
        chk("rst_data_vld", 64'(data_vld), 64'd0);
        chk("rst_free_vld", 64'(free_vld), 64'd0);
        chk("rst_free_addr", 64'(free_addr), 64'd0);
      end
      step(1);
    end
    rst = 1'b0; rd_vld = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 64'(rd_rdy), 64'd1);
    chk("post_rst_r_en", 64'(sram_r_en), 64'd0);
    step(1);

    // 2: single read with latency checks
    data_rdy = 1'b1;
    pop_cycles.delete();
    send(8'h05, 1'b1, 4, ok);
    chk("t2_accept", 64'(ok), 64'd1);
    c0 = acc_cyc;
    @(negedge clk);
    chk("t2_r_en", 64'(sram_r_en), 64'd1);
    chk("t2_sram_addr", 64'(sram_addr), 64'h05);
    @(negedge clk);
    chk("t2_vld_early", 64'(data_vld), 64'd0);
    chk("t2_free_early", 64'(free_vld), 64'd0);
    @(negedge clk);
    chk("t2_cycle", 64'(cyc - c0), 64'd3);
    chk("t2_vld", 64'(data_vld), 64'd1);
    chk("t2_data", 64'(data), 64'hA5A5_0001);
    chk("t2_last", 64'(data_last), 64'd1);
    chk("t2_free_vld", 64'(free_vld), 64'd1);
    chk("t2_free_addr", 64'(free_addr), 64'h05);
    step(1);
    drain("t2_drain");

    // 3: back-to-back stream at full rate
    pop_cycles.delete();
    fbase = free_cnt;
    n_wait = 0;
    for (int i = 0; i < 8; i++) begin
      send(8'(i), (i == 7), 4, ok);
      if (i == 0) c0 = acc_cyc;
    end
    drain("t3_drain");
    chk("t3_rdy_stall", 64'(n_wait), 64'd0);
    chk("t3_words", 64'(pop_cycles.size()), 64'd8);
    chk("t3_first_cycle", 64'(pop_cycles[0]), 64'(c0 + 3));
    chk("t3_last_cycle", 64'(pop_cycles[7]), 64'(c0 + 10));
    chk("t3_frees", 64'(free_cnt - fbase), 64'd8);

    // 4: backpressure fills the buffer
    data_rdy = 1'b0;
    pop_cycles.delete();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      send(8'h20 + 8'(i), (i == 3), 2, ok);
      acc += int'(ok);
    end
    chk("t4_accepted", 64'(acc), 64'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_rdy_full", 64'(rd_rdy), 64'd0);
      step(1);
    end
    @(negedge clk);
    chk("t4_vld_full", 64'(data_vld), 64'd1);
    step(1);
    data_rdy = 1'b1;
    step(1);
    data_rdy = 1'b0;
    @(negedge clk);
    chk("t4_rdy_after_pop", 64'(rd_rdy), 64'd1);
    chk("t4_one_pop", 64'(pop_cycles.size()), 64'd1);
    step(1);
    data_rdy = 1'b1;
    drain("t4_drain");
    chk("t4_words", 64'(pop_cycles.size()), 64'd4);

    // 5: accept and pop together at cnt = OBUF_DEPTH-1
    data_rdy = 1'b0;
    pop_cycles.delete();
    send(8'h30, 1'b0, 2, ok);
    send(8'h31, 1'b0, 2, ok);
    send(8'h32, 1'b1, 2, ok);
    step(4);
    data_rdy = 1'b1;
    send(8'h3F, 1'b1, 0, ok);
    chk("t5_accept", 64'(ok), 64'd1);
    data_rdy = 1'b0;
    @(negedge clk);
    chk("t5_rdy_kept", 64'(rd_rdy), 64'd1);
    step(1);
    send(8'h40, 1'b0, 0, ok);
    chk("t5_accept_to_full", 64'(ok), 64'd1);
    @(negedge clk);
    chk("t5_rdy_full", 64'(rd_rdy), 64'd0);
    step(1);
    data_rdy = 1'b1;
    drain("t5_drain");
    chk("t5_words", 64'(pop_cycles.size()), 64'd5);

    // 6: reset with reads in flight
    send(8'h11, 1'b0, 2, ok);
    send(8'h12, 1'b0, 2, ok);
    send(8'h13, 1'b1, 2, ok);
    rst = 1'b1;
    exp_q.delete();
    exp_free_q.delete();
    step(1);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (data_vld || free_vld) bad++;
      step(1);
    end
    chk("t6_no_output", 64'(bad), 64'd0);
    send(8'h10, 1'b1, 2, ok);
    chk("t6_accept", 64'(ok), 64'd1);
    c0 = acc_cyc;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t6_cycle", 64'(cyc - c0), 64'd3);
    chk("t6_vld", 64'(data_vld), 64'd1);
    chk("t6_data", 64'(data), 64'(sram_mem[8'h10]));
    chk("t6_free_vld", 64'(free_vld), 64'd1);
    chk("t6_free_addr", 64'(free_addr), 64'h10);
    step(1);
    drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
